fifo_read_drain: RTL and testbench

Read-side drain engine for the asynchronous FIFO.
- Lives entirely in the read clock domain.
- Pops words from the FIFO read port (`rreq`/`rdata`/`rempty`) and presents them as a valid/ready stream through a 2-entry output buffer.
- Tags every FRAME_LEN-th word as frame-last and keeps a running count of delivered words.

---
 rtl/fifo_read_drain.sv | 134 +++++++++++++
 tb/tb_fifo_read_drain.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_drain.sv
// Read-domain drain engine: pops the async FIFO into a 2-entry valid/ready
// output buffer, tags frame-last words and counts delivered words.
module fifo_read_drain #(
    parameter int DSIZE     = 8,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 16
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             enable,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rreq,
    output logic             m_valid,
    output logic [DSIZE-1:0] m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic [CNT_W-1:0] word_cnt,
    output logic             frame_done
);
    localparam int POS_W = 16;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [DSIZE-1:0] head_data_q, head_data_d;
    logic [DSIZE-1:0] tail_data_q, tail_data_d;
    logic             head_last_q, head_last_d;
    logic             tail_last_q, tail_last_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic             frame_done_q, frame_done_d;
    logic             pop_s;
    logic             acc_s;
    logic             push_last_s;

    // Pop never looks at m_ready, keeping m_ready off the rreq path.
    always_comb begin
        pop_s       = enable & ~rempty & (state_q != S_FULL) & ~rrst;
        acc_s       = (state_q != S_EMPTY) & m_ready;
        push_last_s = (pos_q == POS_LAST);
    end

    // Buffer occupancy FSM plus frame position, word counter and frame pulse.
    always_comb begin
        state_d      = state_q;
        head_data_d  = head_data_q;
        head_last_d  = head_last_q;
        tail_data_d  = tail_data_q;
        tail_last_d  = tail_last_q;
        pos_d        = pos_q;
        word_cnt_d   = word_cnt_q + {{(CNT_W-1){1'b0}}, acc_s};
        frame_done_d = acc_s & head_last_q;

        case (state_q)
            S_EMPTY: begin
                if (pop_s) begin
                    head_data_d = rdata;
                    head_last_d = push_last_s;
                    state_d     = S_ONE;
                end else begin
                    state_d = S_EMPTY;
                end
            end
            S_ONE: begin
                if (pop_s && acc_s) begin
                    head_data_d = rdata;
                    head_last_d = push_last_s;
                end else if (pop_s) begin
                    tail_data_d = rdata;
                    tail_last_d = push_last_s;
                    state_d     = S_FULL;
                end else if (acc_s) begin
                    state_d = S_EMPTY;
                end else begin
                    state_d = S_ONE;
                end
            end
            S_FULL: begin
                if (acc_s) begin
                    head_data_d = tail_data_q;
                    head_last_d = tail_last_q;
                    state_d     = S_ONE;
                end else begin
                    state_d = S_FULL;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase

        if (pop_s) begin
            pos_d = push_last_s ? {POS_W{1'b0}} : (pos_q + 16'd1);
        end else begin
            pos_d = pos_q;
        end
    end

    // State register with synchronous reset discarding any buffered words.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q      <= S_EMPTY;
            head_data_q  <= {DSIZE{1'b0}};
            head_last_q  <= 1'b0;
            tail_data_q  <= {DSIZE{1'b0}};
            tail_last_q  <= 1'b0;
            pos_q        <= {POS_W{1'b0}};
            word_cnt_q   <= {CNT_W{1'b0}};
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            head_data_q  <= head_data_d;
            head_last_q  <= head_last_d;
            tail_data_q  <= tail_data_d;
            tail_last_q  <= tail_last_d;
            pos_q        <= pos_d;
            word_cnt_q   <= word_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rreq       = pop_s;
    assign m_valid    = (state_q != S_EMPTY);
    assign m_data     = head_data_q;
    assign m_last     = head_last_q;
    assign word_cnt   = word_cnt_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_fifo_read_drain.sv
// Directed bench for fifo_read_drain: two instances (FRAME_LEN 16 and 4)
// fed from simple FIFO models, expected values written out by hand.
module tb_fifo_read_drain;
    logic       rclk = 1'b0;
    logic       rrst;
    logic       en_a, rempty_a, rreq_a, mv_a, ml_a, mr_a, fd_a;
    logic [7:0] rdata_a, md_a;
    logic [15:0] wc_a;
    logic       en_b, rempty_b, rreq_b, mv_b, ml_b, mr_b, fd_b;
    logic [7:0] rdata_b, md_b;
    logic [15:0] wc_b;

    logic [7:0] mem_a [0:255];
    logic [7:0] mem_b [0:255];
    int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;
    int n_tests = 0, n_fail = 0;
    int exp_v, del, fdcnt, base;

    always #5 rclk = ~rclk;

    fifo_read_drain #(.DSIZE(8), .FRAME_LEN(16), .CNT_W(16)) dut_a (
        .rclk(rclk), .rrst(rrst), .enable(en_a), .rempty(rempty_a), .rdata(rdata_a),
        .rreq(rreq_a), .m_valid(mv_a), .m_data(md_a), .m_last(ml_a), .m_ready(mr_a),
        .word_cnt(wc_a), .frame_done(fd_a)
    );

    fifo_read_drain #(.DSIZE(8), .FRAME_LEN(4), .CNT_W(16)) dut_b (
        .rclk(rclk), .rrst(rrst), .enable(en_b), .rempty(rempty_b), .rdata(rdata_b),
        .rreq(rreq_b), .m_valid(mv_b), .m_data(md_b), .m_last(ml_b), .m_ready(mr_b),
        .word_cnt(wc_b), .frame_done(fd_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic upd();
        rempty_a = (rd_a == wr_a);
        rdata_a  = mem_a[rd_a];
        rempty_b = (rd_b == wr_b);
        rdata_b  = mem_b[rd_b];
    endtask

    task automatic push_a(input logic [7:0] v);
        mem_a[wr_a] = v;
        wr_a++;
        upd();
    endtask

    task automatic push_b(input logic [7:0] v);
        mem_b[wr_b] = v;
        wr_b++;
        upd();
    endtask

    // Called after the negedge checks; the FIFO models advance on the pops seen.
    task automatic tick();
        logic pa, pb;
        pa = rreq_a;
        pb = rreq_b;
        @(posedge rclk);
        #1;
        if (pa) rd_a++;
        if (pb) rd_b++;
        upd();
    endtask

    initial begin
        rrst = 1'b1;
        en_a = 1'b0; mr_a = 1'b0; en_b = 1'b0; mr_b = 1'b0;
        upd();
        repeat (2) begin
            @(negedge rclk);
            tick();
        end
        @(negedge rclk);
        check("rst_valid", mv_a, 0);
        check("rst_data", md_a, 0);
        check("rst_cnt", wc_a, 0);
        check("rst_fdone", fd_a, 0);
        check("rst_rreq", rreq_a, 0);
        tick();
        rrst = 1'b0;

        // Straight-through drain of 16 words, FRAME_LEN=16
        for (int i = 1; i <= 16; i++) push_a(8'(i));
        en_a = 1'b1; mr_a = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(negedge rclk);
            check("t1_rreq", rreq_a, (k < 16));
            check("t1_valid", mv_a, (k >= 1 && k <= 16));
            if (k >= 1 && k <= 16) begin
                check("t1_data", md_a, k);
                check("t1_last", ml_a, (k == 16));
            end
            check("t1_fdone", fd_a, (k == 17));
            check("t1_cnt", wc_a, (k < 1) ? 0 : ((k - 1 > 16) ? 16 : k - 1));
            tick();
        end
        @(negedge rclk);
        check("t1_cnt_end", wc_a, 16);
        check("t1_rreq_empty", rreq_a, 0);
        tick();

        // Backpressure: m_ready low for 10 cycles
        base = rd_a;
        for (int i = 1; i <= 16; i++) push_a(8'(i));
        mr_a = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge rclk);
            check("bp_rreq", rreq_a, (k < 2));
            if (k >= 1) begin
                check("bp_valid", mv_a, 1);
                check("bp_hold", md_a, 1);
            end
            tick();
        end
        check("bp_pops", rd_a - base, 2);
        mr_a = 1'b1;
        exp_v = 1; del = 0; fdcnt = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge rclk);
            if (mv_a && mr_a) begin
                check("bp_data", md_a, exp_v);
                check("bp_last", ml_a, (exp_v == 16));
                exp_v++;
                del++;
            end
            if (fd_a) fdcnt++;
            tick();
        end
        check("bp_delivered", del, 16);
        check("bp_fdone_cnt", fdcnt, 1);
        check("bp_cnt", wc_a, 32);

        // FIFO empty for 20 cycles
        for (int k = 0; k < 20; k++) begin
            @(negedge rclk);
            check("idle_rreq", rreq_a, 0);
            check("idle_valid", mv_a, 0);
            check("idle_cnt", wc_a, 32);
            tick();
        end

        // FRAME_LEN=4 instance: 10 words, then 2 more complete frame 3
        for (int i = 1; i <= 10; i++) push_b(8'(i));
        en_b = 1'b1; mr_b = 1'b1;
        exp_v = 1; fdcnt = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge rclk);
            if (mv_b && mr_b) begin
                check("f4_data", md_b, exp_v);
                check("f4_last", ml_b, (exp_v == 4 || exp_v == 8));
                exp_v++;
            end
            if (fd_b) fdcnt++;
            tick();
        end
        check("f4_fdone_cnt", fdcnt, 2);
        check("f4_cnt", wc_b, 10);
        push_b(8'd11);
        push_b(8'd12);
        fdcnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge rclk);
            if (mv_b && mr_b) begin
                check("f4b_data", md_b, exp_v);
                check("f4b_last", ml_b, (exp_v == 12));
                exp_v++;
            end
            if (fd_b) fdcnt++;
            tick();
        end
        check("f4b_fdone_cnt", fdcnt, 1);
        check("f4b_cnt", wc_b, 12);

        // enable dropped after 5 accepts with 2 words buffered
        base = rd_a;
        for (int i = 101; i <= 110; i++) push_a(8'(i));
        exp_v = 101;
        for (int k = 0; k < 15; k++) begin
            en_a = (k < 7);
            mr_a = !(k == 6 || k == 7);
            @(negedge rclk);
            check("en_rreq", rreq_a, (k <= 6));
            if (mv_a && mr_a) begin
                check("en_data", md_a, exp_v);
                exp_v++;
            end
            tick();
        end
        check("en_next", exp_v, 108);
        check("en_pops", rd_a - base, 7);
        check("en_cnt", wc_a, 39);

        // Reset mid-frame with two words buffered
        en_a = 1'b1; mr_a = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge rclk);
            check("rs_rreq_pre", rreq_a, 1);
            tick();
        end
        @(negedge rclk);
        check("rs_full_data", md_a, 108);
        tick();
        rrst = 1'b1;
        @(negedge rclk);
        check("rs_rreq_in_rst", rreq_a, 0);
        tick();
        @(negedge rclk);
        check("rs_rreq_in_rst2", rreq_a, 0);
        check("rs_valid", mv_a, 0);
        check("rs_data", md_a, 0);
        check("rs_cnt", wc_a, 0);
        check("rs_fdone", fd_a, 0);
        tick();
        rd_a = wr_a;
        upd();
        rrst = 1'b0;
        for (int i = 1; i <= 16; i++) push_a(8'(i));
        mr_a = 1'b1;
        exp_v = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge rclk);
            if (mv_a && mr_a) begin
                check("rs_post_data", md_a, exp_v);
                check("rs_post_last", ml_a, (exp_v == 16));
                exp_v++;
            end
            tick();
        end
        check("rs_post_count", exp_v, 17);
        check("rs_post_cnt", wc_a, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
